aes_subshift: RTL
=================

// Module: aes_subshift
// PURPOSE
//  Iterative SubBytes+ShiftRows round stage. Sits directly upstream of mixcolumn in the AES datapath.
//  Accepts one 128-bit state per valid/ready handshake and substitutes BYTES_PER_CYCLE bytes per clock
//  through the forward S-box. It writes each byte to its ShiftRows destination and presents the result
//  held stable until it is consumed.
//  A pass-through last flag tells the downstream stage to bypass mixcolumn on the final round.
// PARAMETERS
//  BYTES_PER_CYCLE  4   S-box lookups per clock; legal values 1,2,4,16; NCYC = 16/BYTES_PER_CYCLE
// PORTS
//  clk        in   1    clock; all state changes on the rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  clear      in   1    synchronous abort; returns the block to IDLE
//  in_valid   in   1    in_state/in_last are valid
//  in_ready   out  1    block can accept a new state
//  in_state   in   128  [1:128]; byte k = [8k+1:8k+8]; column-major (row k%4, column k/4)
//  in_last    in   1    final-round tag
//  out_valid  out  1    out_state/out_last are valid
//  out_ready  in   1    downstream accepts
//  out_state  out  128  ShiftRows(SubBytes(in_state)); same byte layout as in_state
//  out_last   out  1    registered copy of in_last
// BEHAVIOUR
//  Reset (rst_n=0, any time, including mid-operation): FSM=IDLE, cnt=0, in_ready=1, out_valid=0,
//   out_state=0, out_last=0, input latch=0.
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//  - IDLE: in_ready=1. On in_valid&in_ready, latch in_state/in_last, set cnt=0, go to BUSY.
//  - BUSY: in_ready=0. Each edge substitutes input bytes k=cnt*BPC .. cnt*BPC+BPC-1 and writes
//    S(in[k]) to out byte index 4*((c-r)%4)+r, where r=k%4 and c=k/4; then cnt++.
//    After the edge with cnt=NCYC-1, go to DONE.
//  - DONE: out_valid=1; out_state/out_last stay stable while out_ready=0.
//    On out_valid&out_ready go to IDLE; in_ready rises the next cycle.
//  Latency: NCYC edges from the accept edge to out_valid=1 (4 for the default).
//  Throughput: one state per NCYC+2 cycles.
//  out_state holds the previous result until it is overwritten in BUSY; consumers use it only while
//   out_valid=1.
//  clear=1: synchronous, go to IDLE with cnt=0 and out_valid=0; out_state is not cleared.
//   clear overrides a simultaneous accept or output handshake.
//  in_valid while in_ready=0: ignored; no back-pressure buffer.
//  Index arithmetic: cnt is ceil(log2(NCYC)) bits, minimum 1; all row/column math is mod 4 on 2-bit fields.
// STRUCTURE
//  aes_pkg: AES_NB=4, AES_STATE_W=128, the FSM state encoding (IDLE/BUSY/DONE),
//   and function shiftrows_dst(k) returning the destination byte index.
//  Sub-module aes_sbox: combinational 8-bit forward S-box (case table).
//   Instantiated BYTES_PER_CYCLE times with a generate loop.
//  Top level holds the FSM, counter, input latch, output register and byte-lane muxing.
// TESTING
//  1. FIPS-197 App.B round 1: in=193de3bea0f4e22b9ac68d2ae9f84808
//     -> out=d4bf5d30e0b452aeb84111f11e2798e5, out_valid exactly 4 cycles after the accept edge.
//  2. in=all 00 -> out=all 63. in=all 53 -> out=all ED.
//     in bytes 00..0F in order -> out = 63 6b 67 76 ... with ShiftRows ordering, checked against a
//     software model.
//  3. Hold out_ready=0 for 10 cycles in DONE -> out_state/out_valid stable, in_ready=0,
//     a second in_valid is ignored; release -> IDLE.
//  4. Assert rst_n=0 asynchronously at cnt=2 -> outputs reach reset values before the next edge;
//     a fresh state after release is correct.
//  5. clear=1 in BUSY -> IDLE next cycle with out_valid never asserted;
//     clear coincident with out handshake -> IDLE, no double consume.
//  6. Rerun tests 1-2 with BYTES_PER_CYCLE=1, 2 and 16 -> latency 16, 8 and 1; identical out_state;
//     in_last=1 -> out_last=1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, round-stage FSM encoding and ShiftRows index helper.
package aes_pkg;

   localparam int AES_NB      = 4;
   localparam int AES_STATE_W = 128;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Byte k sits at row k%4, column k/4; ShiftRows moves it left by its row number.
   function automatic logic [3:0] shiftrows_dst(input logic [3:0] k);
      logic [1:0] r;
      logic [1:0] c;
      logic [1:0] d;
      r = k[1:0];
      c = k[3:2];
      d = c - r;
      return {d, r};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box (FIPS-197 table).
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   always_comb begin
      y = 8'h00;
      case (a)
         8'h00: y = 8'h63; 8'h01: y = 8'h7c; 8'h02: y = 8'h77; 8'h03: y = 8'h7b; 8'h04: y = 8'hf2; 8'h05: y = 8'h6b; 8'h06: y = 8'h6f; 8'h07: y = 8'hc5;
         8'h08: y = 8'h30; 8'h09: y = 8'h01; 8'h0a: y = 8'h67; 8'h0b: y = 8'h2b; 8'h0c: y = 8'hfe; 8'h0d: y = 8'hd7; 8'h0e: y = 8'hab; 8'h0f: y = 8'h76;
         8'h10: y = 8'hca; 8'h11: y = 8'h82; 8'h12: y = 8'hc9; 8'h13: y = 8'h7d; 8'h14: y = 8'hfa; 8'h15: y = 8'h59; 8'h16: y = 8'h47; 8'h17: y = 8'hf0;
         8'h18: y = 8'had; 8'h19: y = 8'hd4; 8'h1a: y = 8'ha2; 8'h1b: y = 8'haf; 8'h1c: y = 8'h9c; 8'h1d: y = 8'ha4; 8'h1e: y = 8'h72; 8'h1f: y = 8'hc0;
         8'h20: y = 8'hb7; 8'h21: y = 8'hfd; 8'h22: y = 8'h93; 8'h23: y = 8'h26; 8'h24: y = 8'h36; 8'h25: y = 8'h3f; 8'h26: y = 8'hf7; 8'h27: y = 8'hcc;
         8'h28: y = 8'h34; 8'h29: y = 8'ha5; 8'h2a: y = 8'he5; 8'h2b: y = 8'hf1; 8'h2c: y = 8'h71; 8'h2d: y = 8'hd8; 8'h2e: y = 8'h31; 8'h2f: y = 8'h15;
         8'h30: y = 8'h04; 8'h31: y = 8'hc7; 8'h32: y = 8'h23; 8'h33: y = 8'hc3; 8'h34: y = 8'h18; 8'h35: y = 8'h96; 8'h36: y = 8'h05; 8'h37: y = 8'h9a;
         8'h38: y = 8'h07; 8'h39: y = 8'h12; 8'h3a: y = 8'h80; 8'h3b: y = 8'he2; 8'h3c: y = 8'heb; 8'h3d: y = 8'h27; 8'h3e: y = 8'hb2; 8'h3f: y = 8'h75;
         8'h40: y = 8'h09; 8'h41: y = 8'h83; 8'h42: y = 8'h2c; 8'h43: y = 8'h1a; 8'h44: y = 8'h1b; 8'h45: y = 8'h6e; 8'h46: y = 8'h5a; 8'h47: y = 8'ha0;
         8'h48: y = 8'h52; 8'h49: y = 8'h3b; 8'h4a: y = 8'hd6; 8'h4b: y = 8'hb3; 8'h4c: y = 8'h29; 8'h4d: y = 8'he3; 8'h4e: y = 8'h2f; 8'h4f: y = 8'h84;
         8'h50: y = 8'h53; 8'h51: y = 8'hd1; 8'h52: y = 8'h00; 8'h53: y = 8'hed; 8'h54: y = 8'h20; 8'h55: y = 8'hfc; 8'h56: y = 8'hb1; 8'h57: y = 8'h5b;
         8'h58: y = 8'h6a; 8'h59: y = 8'hcb; 8'h5a: y = 8'hbe; 8'h5b: y = 8'h39; 8'h5c: y = 8'h4a; 8'h5d: y = 8'h4c; 8'h5e: y = 8'h58; 8'h5f: y = 8'hcf;
         8'h60: y = 8'hd0; 8'h61: y = 8'hef; 8'h62: y = 8'haa; 8'h63: y = 8'hfb; 8'h64: y = 8'h43; 8'h65: y = 8'h4d; 8'h66: y = 8'h33; 8'h67: y = 8'h85;
         8'h68: y = 8'h45; 8'h69: y = 8'hf9; 8'h6a: y = 8'h02; 8'h6b: y = 8'h7f; 8'h6c: y = 8'h50; 8'h6d: y = 8'h3c; 8'h6e: y = 8'h9f; 8'h6f: y = 8'ha8;
         8'h70: y = 8'h51; 8'h71: y = 8'ha3; 8'h72: y = 8'h40; 8'h73: y = 8'h8f; 8'h74: y = 8'h92; 8'h75: y = 8'h9d; 8'h76: y = 8'h38; 8'h77: y = 8'hf5;
         8'h78: y = 8'hbc; 8'h79: y = 8'hb6; 8'h7a: y = 8'hda; 8'h7b: y = 8'h21; 8'h7c: y = 8'h10; 8'h7d: y = 8'hff; 8'h7e: y = 8'hf3; 8'h7f: y = 8'hd2;
         8'h80: y = 8'hcd; 8'h81: y = 8'h0c; 8'h82: y = 8'h13; 8'h83: y = 8'hec; 8'h84: y = 8'h5f; 8'h85: y = 8'h97; 8'h86: y = 8'h44; 8'h87: y = 8'h17;
         8'h88: y = 8'hc4; 8'h89: y = 8'ha7; 8'h8a: y = 8'h7e; 8'h8b: y = 8'h3d; 8'h8c: y = 8'h64; 8'h8d: y = 8'h5d; 8'h8e: y = 8'h19; 8'h8f: y = 8'h73;
         8'h90: y = 8'h60; 8'h91: y = 8'h81; 8'h92: y = 8'h4f; 8'h93: y = 8'hdc; 8'h94: y = 8'h22; 8'h95: y = 8'h2a; 8'h96: y = 8'h90; 8'h97: y = 8'h88;
         8'h98: y = 8'h46; 8'h99: y = 8'hee; 8'h9a: y = 8'hb8; 8'h9b: y = 8'h14; 8'h9c: y = 8'hde; 8'h9d: y = 8'h5e; 8'h9e: y = 8'h0b; 8'h9f: y = 8'hdb;
         8'ha0: y = 8'he0; 8'ha1: y = 8'h32; 8'ha2: y = 8'h3a; 8'ha3: y = 8'h0a; 8'ha4: y = 8'h49; 8'ha5: y = 8'h06; 8'ha6: y = 8'h24; 8'ha7: y = 8'h5c;
         8'ha8: y = 8'hc2; 8'ha9: y = 8'hd3; 8'haa: y = 8'hac; 8'hab: y = 8'h62; 8'hac: y = 8'h91; 8'had: y = 8'h95; 8'hae: y = 8'he4; 8'haf: y = 8'h79;
         8'hb0: y = 8'he7; 8'hb1: y = 8'hc8; 8'hb2: y = 8'h37; 8'hb3: y = 8'h6d; 8'hb4: y = 8'h8d; 8'hb5: y = 8'hd5; 8'hb6: y = 8'h4e; 8'hb7: y = 8'ha9;
         8'hb8: y = 8'h6c; 8'hb9: y = 8'h56; 8'hba: y = 8'hf4; 8'hbb: y = 8'hea; 8'hbc: y = 8'h65; 8'hbd: y = 8'h7a; 8'hbe: y = 8'hae; 8'hbf: y = 8'h08;
         8'hc0: y = 8'hba; 8'hc1: y = 8'h78; 8'hc2: y = 8'h25; 8'hc3: y = 8'h2e; 8'hc4: y = 8'h1c; 8'hc5: y = 8'ha6; 8'hc6: y = 8'hb4; 8'hc7: y = 8'hc6;
         8'hc8: y = 8'he8; 8'hc9: y = 8'hdd; 8'hca: y = 8'h74; 8'hcb: y = 8'h1f; 8'hcc: y = 8'h4b; 8'hcd: y = 8'hbd; 8'hce: y = 8'h8b; 8'hcf: y = 8'h8a;
         8'hd0: y = 8'h70; 8'hd1: y = 8'h3e; 8'hd2: y = 8'hb5; 8'hd3: y = 8'h66; 8'hd4: y = 8'h48; 8'hd5: y = 8'h03; 8'hd6: y = 8'hf6; 8'hd7: y = 8'h0e;
         8'hd8: y = 8'h61; 8'hd9: y = 8'h35; 8'hda: y = 8'h57; 8'hdb: y = 8'hb9; 8'hdc: y = 8'h86; 8'hdd: y = 8'hc1; 8'hde: y = 8'h1d; 8'hdf: y = 8'h9e;
         8'he0: y = 8'he1; 8'he1: y = 8'hf8; 8'he2: y = 8'h98; 8'he3: y = 8'h11; 8'he4: y = 8'h69; 8'he5: y = 8'hd9; 8'he6: y = 8'h8e; 8'he7: y = 8'h94;
         8'he8: y = 8'h9b; 8'he9: y = 8'h1e; 8'hea: y = 8'h87; 8'heb: y = 8'he9; 8'hec: y = 8'hce; 8'hed: y = 8'h55; 8'hee: y = 8'h28; 8'hef: y = 8'hdf;
         8'hf0: y = 8'h8c; 8'hf1: y = 8'ha1; 8'hf2: y = 8'h89; 8'hf3: y = 8'h0d; 8'hf4: y = 8'hbf; 8'hf5: y = 8'he6; 8'hf6: y = 8'h42; 8'hf7: y = 8'h68;
         8'hf8: y = 8'h41; 8'hf9: y = 8'h99; 8'hfa: y = 8'h2d; 8'hfb: y = 8'h0f; 8'hfc: y = 8'hb0; 8'hfd: y = 8'h54; 8'hfe: y = 8'hbb; 8'hff: y = 8'h16;
         default: y = 8'h00;
      endcase
   end

endmodule

// File: rtl/aes_subshift.sv
// Iterative SubBytes+ShiftRows stage: BYTES_PER_CYCLE S-box lookups per clock,
// each result scattered straight to its ShiftRows position in the output register.
module aes_subshift
   import aes_pkg::*;
#(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_STATE_W-1:0] in_state,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_STATE_W-1:0] out_state,
   output logic                   out_last
);

   localparam int NBYTES = AES_STATE_W / 8;
   localparam int NCYC   = NBYTES / BYTES_PER_CYCLE;
   localparam int CNT_W  = (NCYC > 1) ? $clog2(NCYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

   state_t                 state_reg;
   state_t                 state_next;
   logic [CNT_W-1:0]       cnt_reg;
   logic [AES_STATE_W-1:0] in_latch_reg;
   logic                   last_latch_reg;
   logic [7:0]             out_bytes_reg [NBYTES];
   logic                   out_last_reg;

   logic                   accept;
   logic                   busy_last;
   logic [7:0]             in_bytes [NBYTES];
   logic [3:0]             lane_k   [BYTES_PER_CYCLE];
   logic [7:0]             lane_sub [BYTES_PER_CYCLE];

   assign in_ready  = (state_reg == ST_IDLE);
   assign out_valid = (state_reg == ST_DONE);
   assign out_last  = out_last_reg;
   assign accept    = in_valid & in_ready & ~clear;
   assign busy_last = (state_reg == ST_BUSY) && (cnt_reg == CNT_LAST);

   // Byte 0 occupies the most significant bits of the packed state.
   generate
      for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
         assign in_bytes[gi] = in_latch_reg[AES_STATE_W-1-8*gi -: 8];
         assign out_state[AES_STATE_W-1-8*gi -: 8] = out_bytes_reg[gi];
      end
   endgenerate

   generate
      for (genvar gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_lanes
         assign lane_k[gi] = 4'((32'(cnt_reg) * BYTES_PER_CYCLE) + gi);
         aes_sbox u_sbox (
            .a (in_bytes[lane_k[gi]]),
            .y (lane_sub[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE: if (in_valid)  state_next = ST_BUSY;
         ST_BUSY: if (busy_last) state_next = ST_DONE;
         ST_DONE: if (out_ready) state_next = ST_IDLE;
         default:                state_next = ST_IDLE;
      endcase
      if (clear) begin
         state_next = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg        <= '0;
         in_latch_reg   <= '0;
         last_latch_reg <= 1'b0;
         out_last_reg   <= 1'b0;
         for (int i = 0; i < NBYTES; i++) begin
            out_bytes_reg[i] <= 8'h00;
         end
      end else if (clear) begin
         cnt_reg <= '0;
      end else if (accept) begin
         cnt_reg        <= '0;
         in_latch_reg   <= in_state;
         last_latch_reg <= in_last;
      end else if (state_reg == ST_BUSY) begin
         for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
            out_bytes_reg[shiftrows_dst(lane_k[i])] <= lane_sub[i];
         end
         cnt_reg <= busy_last ? '0 : cnt_reg + 1'b1;
         if (busy_last) begin
            out_last_reg <= last_latch_reg;
         end
      end
   end

endmodule
